// File: rtl/sif_pkg.sv
// Shared types and constants for the SIF register bridge.
// The read-miss value lives here so the top level and the bench agree on it.
package sif_pkg;
    localparam int SIF_DW = 16;

    typedef logic [SIF_DW-1:0] sif_word_t;

    localparam sif_word_t SIF_RD_MISS = 16'h0000;
endpackage

// File: rtl/sif_regfile.sv
// DEPTH x 16 register storage: synchronous write port and a registered read port.
// A read and a write in the same cycle return the pre-write contents.
module sif_regfile
    import sif_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  sif_word_t                i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output sif_word_t                o_rdata
);
    sif_word_t r_mem [DEPTH];
    sif_word_t r_rdata;

    // Both ports act on the same edge; nonblocking semantics give read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sif_modport.sv
// SIF register bridge: XA decode onto a local register file, miss read-back of zero,
// and a one-cycle-delayed write-announce (WA) mirror of every accepted XA write.
module sif_modport
    import sif_pkg::*;
#(
    parameter int          DEPTH = 16,
    parameter logic [15:0] BASE  = 16'h0000
) (
    input  logic      clk,
    input  logic      rst,
    input  sif_word_t xa_addr,
    input  sif_word_t xa_data_wr,
    input  logic      xa_wr_s,
    input  logic      xa_rd_s,
    output sif_word_t xa_data_rd,
    output sif_word_t wa_addr,
    output sif_word_t wa_data_wr,
    output logic      wa_wr_s
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    // Strobe protocol: a strobe high at a rising edge is one accepted transfer.
    // There is no ready; every strobe outside reset is taken, back-to-back included.
    sif_word_t         w_offset;
    logic              w_hit;
    logic [AW-1:0]     w_idx;
    sif_word_t         w_rf_rdata;

    logic              r_rd_hit;
    sif_word_t         r_wa_addr;
    sif_word_t         r_wa_data;
    logic              r_wa_wr_s;

    // Unsigned 16-bit offset; a 17-bit compare lets BASE+DEPTH reach 16'h10000.
    assign w_offset = xa_addr - BASE;
    assign w_hit    = {1'b0, w_offset} < DEPTH_W;
    assign w_idx    = w_offset[AW-1:0];

    sif_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (xa_wr_s & w_hit),
        .i_waddr (w_idx),
        .i_wdata (xa_data_wr),
        .i_re    (xa_rd_s & w_hit),
        .i_raddr (w_idx),
        .o_rdata (w_rf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_hit  <= 1'b0;
            r_wa_addr <= '0;
            r_wa_data <= '0;
            r_wa_wr_s <= 1'b0;
        end else begin
            r_wa_wr_s <= xa_wr_s;
            if (xa_wr_s) begin
                r_wa_addr <= xa_addr;
                r_wa_data <= xa_data_wr;
            end
            if (xa_rd_s) begin
                r_rd_hit <= w_hit;
            end
        end
    end

    // Both r_rd_hit and the regfile read register only move on a read, so this holds.
    assign xa_data_rd = r_rd_hit ? w_rf_rdata : SIF_RD_MISS;
    assign wa_addr    = r_wa_addr;
    assign wa_data_wr = r_wa_data;
    assign wa_wr_s    = r_wa_wr_s;
endmodule

// File: tb/tb_sif_modport.sv
// Bench for sif_modport: randomized XA traffic against an array-based register model,
// with expected read data and WA mirrors queued by the driver and popped by a monitor.
module tb_sif_modport;
    localparam int          DEPTH = 16;
    localparam logic [15:0] BASE  = 16'h0000;

    logic        clk;
    logic        rst;
    logic [15:0] xa_addr;
    logic [15:0] xa_data_wr;
    logic        xa_wr_s;
    logic        xa_rd_s;
    logic [15:0] xa_data_rd;
    logic [15:0] wa_addr;
    logic [15:0] wa_data_wr;
    logic        wa_wr_s;

    sif_modport #(
        .DEPTH (DEPTH),
        .BASE  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .xa_addr    (xa_addr),
        .xa_data_wr (xa_data_wr),
        .xa_wr_s    (xa_wr_s),
        .xa_rd_s    (xa_rd_s),
        .xa_data_rd (xa_data_rd),
        .wa_addr    (wa_addr),
        .wa_data_wr (wa_data_wr),
        .wa_wr_s    (wa_wr_s)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] rd_exp_q [$];
    logic [31:0] wa_exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic bit ref_hit(input logic [15:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of inputs at a falling edge and records what the DUT owes.
    task automatic cyc(input bit r, input bit wr, input bit rd,
                       input logic [15:0] a, input logic [15:0] d);
        rst        = r;
        xa_wr_s    = wr;
        xa_rd_s    = rd;
        xa_addr    = a;
        xa_data_wr = d;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
        end else begin
            if (rd) rd_exp_q.push_back(ref_hit(a) ? ref_mem[int'(a) - int'(BASE)] : 16'h0000);
            if (wr) begin
                wa_exp_q.push_back({a, d});
                if (ref_hit(a)) ref_mem[int'(a) - int'(BASE)] = d;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 16'($urandom), 16'($urandom));
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit          mon_en = 0;
    bit          rst_seen = 0, rd_seen = 0, wr_seen = 0;
    logic [15:0] hold_rd = 16'h0, hold_wa_addr = 16'h0, hold_wa_data = 16'h0;

    always @(posedge clk) begin
        rst_seen = rst;
        rd_seen  = xa_rd_s && !rst;
        wr_seen  = xa_wr_s && !rst;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                hold_rd      = 16'h0;
                hold_wa_addr = 16'h0;
                hold_wa_data = 16'h0;
            end
            if (rd_seen) begin
                if (rd_exp_q.size() == 0) chk("rd_q_underflow", 1, 0);
                else hold_rd = rd_exp_q.pop_front();
            end
            if (wr_seen) begin
                if (wa_exp_q.size() == 0) chk("wa_q_underflow", 1, 0);
                else {hold_wa_addr, hold_wa_data} = wa_exp_q.pop_front();
            end
            chk("wa_wr_s", 32'(wa_wr_s), 32'(wr_seen));
            chk("xa_data_rd", 32'(xa_data_rd), 32'(hold_rd));
            chk("wa_addr", 32'(wa_addr), 32'(hold_wa_addr));
            chk("wa_data_wr", 32'(wa_data_wr), 32'(hold_wa_data));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; xa_wr_s = 1'b0; xa_rd_s = 1'b0; xa_addr = '0; xa_data_wr = '0;
        @(posedge clk);
        mon_en = 1;
        @(negedge clk);

        // Reset with strobes high: nothing accepted, no WA pulse.
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 16'($urandom_range(0, 15)), 16'($urandom));
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 16'(i), 16'h0);

        // Directed: hit write/read, miss write/read, same-cycle read-before-write.
        cyc(0, 1, 0, 16'h0003, 16'hA5A5);
        cyc(0, 0, 1, 16'h0003, 16'h0);
        cyc(0, 1, 0, 16'h0100, 16'h1234);
        cyc(0, 0, 1, 16'h0100, 16'h0);
        idle(2);
        cyc(0, 1, 0, 16'h0005, 16'h1111);
        cyc(0, 1, 1, 16'h0005, 16'hBEEF);
        cyc(0, 0, 1, 16'h0005, 16'h0);
        cyc(0, 0, 1, 16'hFFFF, 16'h0);
        idle(3);

        // Back-to-back writes then back-to-back readback.
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 16'(i), 16'(i * 16'h0101));
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 16'(i), 16'h0);

        // Random mix of hits, misses, simultaneous strobes and idles.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, DEPTH - 1)) : 16'($urandom);
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
        end

        // Write immediately followed by reset: the pulse is then cleared.
        cyc(0, 1, 0, 16'h0007, 16'h7777);
        cyc(1, 0, 0, 16'h0, 16'h0);
        cyc(1, 1, 1, 16'h0007, 16'h5555);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 16'(i), 16'h0);
        idle(3);

        mon_en = 0;
        chk("rd_q_drained", 32'(rd_exp_q.size()), 0);
        chk("wa_q_drained", 32'(wa_exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sif_modport.md
# sif_modport

Simple-interface (SIF) register bridge. An external-access (XA) master writes and reads 16-bit words over a one-cycle strobe protocol. The block keeps a local register file and mirrors every accepted XA write onto a write-announce (WA) output port one cycle later. It sits between the SIF testbench/host side and downstream logic that tracks register writes.

## Interface
Parameters:
- DEPTH, 16: number of local 16-bit registers (power of two, 2..256).
- BASE, 16'h0000: first XA address mapped to the register file; must be DEPTH-aligned.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- rst  in  1  reset, active-high, synchronous (one clock; reset is synchronous and active-high).
- xa_addr  in  16  XA word address, sampled when a strobe is high.
- xa_data_wr  in  16  XA write data, sampled with xa_wr_s.
- xa_wr_s  in  1  XA write strobe, one cycle per transfer.
- xa_rd_s  in  1  XA read strobe, one cycle per transfer.
- xa_data_rd  out  16  XA read data, registered.
- wa_addr  out  16  address of the mirrored write.
- wa_data_wr  out  16  data of the mirrored write.
- wa_wr_s  out  1  mirrored-write strobe, single-cycle pulse.

## Operation
- Hit: BASE <= xa_addr < BASE+DEPTH. The index is xa_addr - BASE.
- Write (xa_wr_s=1 at an edge):
  - On a hit, update the register at that index.
  - Whether or not it hits, mirror the write onto WA: wa_addr <= xa_addr, wa_data_wr <= xa_data_wr, wa_wr_s <= 1.
- Read (xa_rd_s=1 at an edge):
  - On a hit, xa_data_rd <= register contents.
  - On a miss, xa_data_rd <= 16'h0000.
  - xa_data_rd holds its value until the next read or reset.
- Simultaneous xa_wr_s and xa_rd_s: both are accepted. The read returns the pre-write contents (read-before-write), and the write is applied and mirrored normally.
- No strobe: registers unchanged, wa_wr_s=0, and wa_addr/wa_data_wr hold their last values.
- No back-pressure: every strobe is accepted, so back-to-back cycles are fully supported.

## Timing
- Reset (rst=1 at an edge): all registers, xa_data_rd, wa_addr and wa_data_wr go to 0, and wa_wr_s goes to 0.
- Strobes sampled during reset are dropped and produce no WA pulse.
- Read latency: 1 cycle. Data is valid on the edge after the strobe edge and stays valid after that.
- WA latency: 1 cycle. wa_wr_s is high for exactly the cycle after each accepted write.
- N consecutive writes produce N consecutive wa_wr_s cycles.
- Write-then-read of the same address on the next cycle returns the new data.
- Reset asserted one cycle after a write: the write's WA pulse, already registered, is cleared by reset (rst has priority over all updates).
- Address arithmetic is unsigned 16-bit. With BASE+DEPTH=16'h10000 the top of the space hits, with no wrap.

## Structure
- Shared package sif_pkg:
  - typedef sif_word_t = logic [15:0]
  - constant SIF_DW = 16
  - constant SIF_RD_MISS = 16'h0000
- One sub-module sif_regfile: DEPTH x 16 storage with a synchronous write port and a registered read port (read-before-write).
- The top level adds the address decode, the miss mux and the WA mirror registers.

## Test plan
- Reset: hold rst for 5 cycles with strobes high -> all outputs 0, no wa_wr_s pulse, and every register reads 0x0000 afterwards.
- Write addr 0x0003 data 0xA5A5 -> next cycle wa_wr_s=1, wa_addr=0x0003, wa_data_wr=0xA5A5. A following read of 0x0003 gives xa_data_rd=0xA5A5 one cycle after the strobe.
- Miss: write 0x0100 data 0x1234 -> WA mirrors 0x0100/0x1234. A read of 0x0100 returns 0x0000.
- Same-cycle write 0x0005 data 0xBEEF with read 0x0005 (old value 0x1111) -> xa_data_rd=0x1111. The next read returns 0xBEEF.
- Back-to-back writes to 0..15 with data = addr*0x0101 -> 16 consecutive wa_wr_s cycles in order. Readback of all 16 registers matches.
